// File: rtl/relu_wb_pkg.sv
// Shared constants and FSM state type for the ReLU writeback controller.
package relu_wb_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned HALFWORD_W = 16;
  localparam int unsigned WORD_W     = LANES * BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/relu_wb_fifo.sv
// Synchronous writeback FIFO; count/full/empty are registered, head is a
// read of the storage array masked to zero while empty.
module relu_wb_fifo
  import relu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = WORD_W
) (
  input  logic                     clk_cal,
  input  logic                     rst_cal,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] cnt_nxt;

  // Qualify requests and compute the next occupancy.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    cnt_nxt = count;
    if (do_push && !do_pop) begin
      cnt_nxt = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      cnt_nxt = count - CNT_W'(1);
    end
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CNT_W'(DEPTH));
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk_cal) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head_c = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/relu_wb_ctrl.sv
// Per-layer sequencer and SRAM writeback scheduler for the 8-lane ReLU bank.
// Optional write-stall performance counter enabled by RELU_WB_PERF_EN.
module relu_wb_ctrl
  import relu_wb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LANES      = relu_wb_pkg::LANES
) (
  input  logic                      clk_cal,
  input  logic                      rst_cal,
  input  logic                      start,
  input  logic [3:0]                nn_layer_cnt,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic [ADDR_W-1:0]         cfg_num_words,
  input  logic                      cfg_relu_max,
  output logic                      relu_max,
  input  logic [LANES*BYTE_W-1:0]   relu_dout,
  input  logic [LANES-1:0]          relu_dout_vld,
  output logic                      acc_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [LANES*BYTE_W-1:0]   wr_data,
  input  logic                      wr_ready,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                layer_id,
  output logic                      err_lane,
  output logic                      err_ovf,
  output logic [HALFWORD_W-1:0]     perf_stall_cnt
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW    = LANES * BYTE_W;

  wb_state_e         state;
  wb_state_e         state_nxt;
  logic [ADDR_W-1:0] num_words;
  logic [ADDR_W-1:0] acc_cnt;
  logic              cfg_load;
  logic              push;
  logic              pop;
  logic              acc_inc;
  logic              lane_err_set;
  logic              ovf_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  fifo_cnt_nxt;
  logic [DW-1:0]     fifo_head_c;
  logic              vld_all;
  logic              vld_none;

  assign vld_all  = &relu_dout_vld;
  assign vld_none = ~|relu_dout_vld;
  assign pop      = ~fifo_empty & wr_ready;
  assign wr_en    = ~fifo_empty;
  assign wr_data  = fifo_head_c;

  relu_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DW)
  ) u_fifo (
    .clk_cal (clk_cal),
    .rst_cal (rst_cal),
    .push    (push),
    .wdata   (relu_dout),
    .pop     (pop),
    .head_c  (fifo_head_c),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // State register.
  always_ff @(posedge clk_cal) begin
    if (rst_cal) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt    = state;
    cfg_load     = 1'b0;
    push         = 1'b0;
    acc_inc      = 1'b0;
    lane_err_set = 1'b0;
    ovf_set      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cfg_load  = 1'b1;
          state_nxt = (cfg_num_words == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (vld_all) begin
          // A dropped word still counts so the layer always terminates.
          acc_inc = 1'b1;
          if (!fifo_full || pop) push = 1'b1;
          else                   ovf_set = 1'b1;
          if (acc_cnt + ADDR_W'(1) == num_words) state_nxt = ST_DRAIN;
        end else if (!vld_none) begin
          lane_err_set = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Occupancy after this edge, used to register the stall output.
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop)      fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
    else if (!push && pop) fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
  end

  // Layer configuration, counters, sticky flags and registered status.
  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      num_words <= '0;
      acc_cnt   <= '0;
      wr_addr   <= '0;
      relu_max  <= 1'b0;
      layer_id  <= '0;
      err_lane  <= 1'b0;
      err_ovf   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_stall <= 1'b0;
    end else begin
      if (cfg_load) begin
        num_words <= cfg_num_words;
        acc_cnt   <= '0;
        wr_addr   <= cfg_base_addr;
        relu_max  <= cfg_relu_max;
        layer_id  <= nn_layer_cnt;
        err_lane  <= 1'b0;
        err_ovf   <= 1'b0;
      end else begin
        if (acc_inc)      acc_cnt  <= acc_cnt + ADDR_W'(1);
        if (pop)          wr_addr  <= wr_addr + ADDR_W'(1);
        if (lane_err_set) err_lane <= 1'b1;
        if (ovf_set)      err_ovf  <= 1'b1;
      end
      busy      <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      done      <= (state_nxt == ST_DONE);
      acc_stall <= (state_nxt == ST_RUN) &&
                   (fifo_cnt_nxt >= CNT_W'(FIFO_DEPTH - 1));
    end
  end

`ifdef RELU_WB_PERF_EN
  logic [HALFWORD_W-1:0] perf_q;

  // Saturating count of cycles where a pending write is refused.
  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      perf_q <= '0;
    end else if (cfg_load) begin
      perf_q <= '0;
    end else if (((state == ST_RUN) || (state == ST_DRAIN)) && wr_en && !wr_ready &&
                 (perf_q != {HALFWORD_W{1'b1}})) begin
      perf_q <= perf_q + HALFWORD_W'(1);
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_relu_wb_ctrl.sv
// Randomized self-checking bench for relu_wb_ctrl against a queue-based model.
module tb_relu_wb_ctrl;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk_cal = 1'b0;
  logic              rst_cal;
  logic              start;
  logic [3:0]        nn_layer_cnt;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [ADDR_W-1:0] cfg_num_words;
  logic              cfg_relu_max;
  logic              relu_max;
  logic [63:0]       relu_dout;
  logic [7:0]        relu_dout_vld;
  logic              acc_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              wr_ready;
  logic              busy;
  logic              done;
  logic [3:0]        layer_id;
  logic              err_lane;
  logic              err_ovf;
  logic [15:0]       perf_stall_cnt;

  always #5 clk_cal = ~clk_cal;

  relu_wb_ctrl dut (
    .clk_cal        (clk_cal),
    .rst_cal        (rst_cal),
    .start          (start),
    .nn_layer_cnt   (nn_layer_cnt),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_words  (cfg_num_words),
    .cfg_relu_max   (cfg_relu_max),
    .relu_max       (relu_max),
    .relu_dout      (relu_dout),
    .relu_dout_vld  (relu_dout_vld),
    .acc_stall      (acc_stall),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .busy           (busy),
    .done           (done),
    .layer_id       (layer_id),
    .err_lane       (err_lane),
    .err_ovf        (err_ovf),
    .perf_stall_cnt (perf_stall_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 completion cycle.
  int          m_phase = 0;
  logic [63:0] m_q[$];
  int          m_base = 0, m_num = 0, m_acc = 0, m_wr = 0, m_layer = 0, m_perf = 0;
  bit          m_rmax = 0, m_elane = 0, m_eovf = 0;

  int          n_wr = 0;
  logic [9:0]  wr_log[$];

  task automatic model_edge();
    int sz0;
    bit pop;
    sz0 = m_q.size();
    pop = (sz0 > 0) && wr_ready;
    if (rst_cal) begin
      m_phase = 0; m_q.delete();
      m_base = 0; m_num = 0; m_acc = 0; m_wr = 0; m_layer = 0; m_perf = 0;
      m_rmax = 0; m_elane = 0; m_eovf = 0;
      return;
    end
`ifdef RELU_WB_PERF_EN
    if ((m_phase == 1 || m_phase == 2) && sz0 > 0 && !wr_ready && m_perf < 65535) m_perf++;
`endif
    if (pop) begin
      void'(m_q.pop_front());
      m_wr++;
    end
    case (m_phase)
      0: if (start) begin
           m_base = int'(cfg_base_addr); m_num = int'(cfg_num_words);
           m_rmax = cfg_relu_max; m_layer = int'(nn_layer_cnt);
           m_elane = 0; m_eovf = 0; m_acc = 0; m_wr = 0; m_perf = 0;
           m_phase = (m_num == 0) ? 3 : 1;
         end
      1: if (relu_dout_vld == 8'hFF) begin
           m_acc++;
           if (sz0 < DEPTH || pop) m_q.push_back(relu_dout);
           else                    m_eovf = 1;
           if (m_acc == m_num) m_phase = 2;
         end else if (relu_dout_vld != 8'h00) begin
           m_elane = 1;
         end
      2: if (sz0 == 0) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    int sz;
    sz = m_q.size();
    check_eq("wr_en",     wr_en,     sz > 0);
    check_eq("wr_addr",   wr_addr,   64'((m_base + m_wr) % 1024));
    check_eq("wr_data",   wr_data,   (sz > 0) ? m_q[0] : 64'h0);
    check_eq("acc_stall", acc_stall, (m_phase == 1) && (sz >= DEPTH - 1));
    check_eq("busy",      busy,      (m_phase == 1) || (m_phase == 2));
    check_eq("done",      done,      m_phase == 3);
    check_eq("relu_max",  relu_max,  m_rmax);
    check_eq("layer_id",  layer_id,  64'(m_layer));
    check_eq("err_lane",  err_lane,  m_elane);
    check_eq("err_ovf",   err_ovf,   m_eovf);
    check_eq("perf",      perf_stall_cnt, 64'(m_perf));
  endtask

  // One clock: log handshake, advance model at the edge, compare mid-cycle.
  task automatic tick();
    if (wr_en && wr_ready) begin
      n_wr++;
      wr_log.push_back(wr_addr);
    end
    @(posedge clk_cal);
    model_edge();
    @(negedge clk_cal);
    check_outputs();
  endtask

  task automatic start_layer(input int base, input int num, input bit rmax, input int layer);
    cfg_base_addr = ADDR_W'(base);
    cfg_num_words = ADDR_W'(num);
    cfg_relu_max  = rmax;
    nn_layer_cnt  = 4'(layer);
    relu_dout_vld = 8'h00;
    start         = 1'b1;
    n_wr = 0;
    wr_log.delete();
    tick();
    start         = 1'b0;
    cfg_base_addr = ADDR_W'($urandom);
    cfg_num_words = ADDR_W'($urandom);
    cfg_relu_max  = 1'($urandom);
    nn_layer_cnt  = 4'($urandom);
  endtask

  task automatic run_words(input bit obey, input int p_ready, input int bad_pct,
                           input int gap_pct, input int hold);
    int guard;
    guard = 0;
    while (m_phase == 1 && guard < 3000) begin
      relu_dout = {$urandom, $urandom};
      if (obey && (m_q.size() >= DEPTH - 1))          relu_dout_vld = 8'h00;
      else if ($urandom_range(0, 99) < bad_pct)       relu_dout_vld = 8'($urandom_range(1, 254));
      else if ($urandom_range(0, 99) < gap_pct)       relu_dout_vld = 8'h00;
      else                                            relu_dout_vld = 8'hFF;
      if (hold > 0) begin
        wr_ready = 1'b0;
        if (m_q.size() > 0) hold--;
      end else begin
        wr_ready = ($urandom_range(0, 99) < p_ready);
      end
      start = ($urandom_range(0, 9) == 0);
      tick();
      guard++;
    end
    start         = 1'b0;
    relu_dout_vld = 8'h00;
    check_eq("run_bound", guard < 3000, 1'b1);
  endtask

  task automatic wait_done(input int p_ready);
    int guard;
    guard = 0;
    relu_dout_vld = 8'h00;
    while (m_phase != 3 && guard < 3000) begin
      wr_ready = ($urandom_range(0, 99) < p_ready);
      start    = ($urandom_range(0, 9) == 0);
      tick();
      guard++;
    end
    start    = 1'b0;
    wr_ready = 1'b1;
    check_eq("done_bound", guard < 3000, 1'b1);
    tick();
  endtask

  initial begin
    rst_cal = 1'b1; start = 1'b0; nn_layer_cnt = '0; cfg_base_addr = '0;
    cfg_num_words = '0; cfg_relu_max = 1'b0; relu_dout = '0; relu_dout_vld = '0;
    wr_ready = 1'b1;
    @(negedge clk_cal);
    tick();
    tick();
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_wr_data", wr_data, 64'h0);
    rst_cal = 1'b0;
    tick();

    // Basic layer: three back-to-back words at 0x010.
    start_layer(12'h010, 3, 1'b1, 5);
    run_words(1'b1, 100, 0, 0, 0);
    wait_done(100);
    check_eq("basic_nwr", 64'(n_wr), 64'd3);
    if (wr_log.size() == 3) begin
      check_eq("basic_a0", wr_log[0], 10'h010);
      check_eq("basic_a1", wr_log[1], 10'h011);
      check_eq("basic_a2", wr_log[2], 10'h012);
    end

    // Backpressure: ten refused write cycles with an obedient upstream.
    start_layer(12'h100, 8, 1'b0, 2);
    run_words(1'b1, 100, 0, 0, 10);
    wait_done(100);
    check_eq("bp_ovf", err_ovf, 1'b0);
    check_eq("bp_nwr", 64'(n_wr), 64'd8);
`ifdef RELU_WB_PERF_EN
    check_eq("bp_perf", perf_stall_cnt, 64'd10);
`else
    check_eq("bp_perf", perf_stall_cnt, 64'd0);
`endif

    // Overflow: six words into a stalled four-deep buffer.
    start_layer(12'h200, 6, 1'b1, 3);
    run_words(1'b0, 0, 0, 0, 20);
    wait_done(100);
    check_eq("ovf_flag", err_ovf, 1'b1);
    check_eq("ovf_nwr", 64'(n_wr), 64'd4);

    // Lane error: one partial valid, then two good words.
    start_layer(12'h020, 2, 1'b0, 4);
    relu_dout = {$urandom, $urandom};
    relu_dout_vld = 8'h7F;
    tick();
    run_words(1'b1, 100, 0, 0, 0);
    wait_done(100);
    check_eq("lane_flag", err_lane, 1'b1);
    check_eq("lane_nwr", 64'(n_wr), 64'd2);

    // Zero-length layer; its start also clears the lane error.
    start_layer(12'h000, 0, 1'b1, 6);
    check_eq("zero_lane_clr", err_lane, 1'b0);
    check_eq("zero_done", done, 1'b1);
    check_eq("zero_wr_en", wr_en, 1'b0);
    tick();
    check_eq("zero_done_off", done, 1'b0);

    // Address wrap at the top of the SRAM.
    start_layer(12'h3FF, 2, 1'b0, 1);
    run_words(1'b1, 100, 0, 0, 0);
    wait_done(100);
    if (wr_log.size() == 2) begin
      check_eq("wrap_a0", wr_log[0], 10'h3FF);
      check_eq("wrap_a1", wr_log[1], 10'h000);
    end
    check_eq("wrap_nwr", 64'(n_wr), 64'd2);

    // Reset mid-run after one of four words.
    start_layer(12'h050, 4, 1'b1, 7);
    relu_dout = {$urandom, $urandom};
    relu_dout_vld = 8'hFF;
    wr_ready = 1'b0;
    tick();
    relu_dout_vld = 8'h00;
    rst_cal = 1'b1;
    tick();
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_done", done, 1'b0);
    check_eq("mrst_wr_en", wr_en, 1'b0);
    check_eq("mrst_relu_max", relu_max, 1'b0);
    rst_cal = 1'b0;
    wr_ready = 1'b1;
    tick();
    start_layer(12'h050, 4, 1'b1, 7);
    run_words(1'b1, 100, 0, 0, 0);
    wait_done(100);
    check_eq("mrst_nwr", 64'(n_wr), 64'd4);

    // Randomized layers.
    for (int i = 0; i < 25; i++) begin
      int pr;
      pr = $urandom_range(30, 100);
      start_layer($urandom_range(0, 1023), $urandom_range(0, 12), 1'($urandom), $urandom_range(0, 15));
      if (m_phase == 1) run_words(1'($urandom), pr, $urandom_range(0, 20), $urandom_range(0, 30), 0);
      wait_done(pr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
